// File: rtl/bus_memory_controller.sv
// bus_memory_controller
//   Shared-bus memory slave. Serves single-word reads and write-backs from the
//   granted cache master using a word-addressed backing store with a fixed
//   access latency. On reads, a cache-to-cache intervention (snoopHit plus
//   snoopFunctionComplete) preempts memory; the supplied word is returned to
//   the requester and written back into the store.
//
// Ports
//   clock                 : system clock, rising edge
//   reset                 : asynchronous reset, active low
//   address               : word address from the granted master
//   dataOut               : write data from the master
//   dataIn                : read data to the master (registered)
//   readEnabled           : master read request (level)
//   writeEnabled          : master write request (level, wins over read)
//   functionComplete      : transaction done, held until both enables drop
//   snoopHit              : some snooper owns the addressed block
//   snoopFunctionComplete : owning snooper has placed data on snoopDataIn
//   snoopDataIn           : intervention data from the owning cache
//   busy                  : high whenever the controller is not idle
module bus_memory_controller #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 16,
    parameter int SIZE_IN_WORDS = 256,
    parameter int LATENCY       = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0]    dataOut,
    output logic [DATA_WIDTH-1:0]    dataIn,
    input  logic                     readEnabled,
    input  logic                     writeEnabled,
    output logic                     functionComplete,
    input  logic                     snoopHit,
    input  logic                     snoopFunctionComplete,
    input  logic [DATA_WIDTH-1:0]    snoopDataIn,
    output logic                     busy
);

    localparam int         IDX_W    = $clog2(SIZE_IN_WORDS);
    localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        COMPLETE
    } state_e;

    state_e                  state_q;
    logic [IDX_W-1:0]        idx_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   snoop_data_q;
    logic [DATA_WIDTH-1:0]   data_in_q;
    logic                    write_q;
    logic                    snoop_q;
    logic                    fc_q;
    logic                    busy_q;
    logic [3:0]              cnt_q;

    logic [DATA_WIDTH-1:0]   mem_q [SIZE_IN_WORDS];

    logic                    mem_we;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    // Upper address bits are deliberately ignored (index wraps).
    logic unused_address;
    assign unused_address = ^address;

    assign dataIn           = data_in_q;
    assign functionComplete = fc_q;
    assign busy             = busy_q;

    // Store update: write-back when the latency expires, or the flush of an
    // intervening owner's word on the first COMPLETE cycle.
    always_comb begin
        mem_we    = 1'b0;
        mem_wdata = wdata_q;
        if (state_q == ACCESS && write_q && cnt_q == 4'd0) begin
            mem_we = 1'b1;
        end
        if (state_q == COMPLETE && !fc_q && snoop_q) begin
            mem_we    = 1'b1;
            mem_wdata = snoop_data_q;
        end
    end

    // The store has no reset so its contents survive a reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[idx_q] <= mem_wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            wdata_q      <= '0;
            snoop_data_q <= '0;
            data_in_q    <= '0;
            write_q      <= 1'b0;
            snoop_q      <= 1'b0;
            fc_q         <= 1'b0;
            busy_q       <= 1'b0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (writeEnabled) begin
                        idx_q   <= address[IDX_W-1:0];
                        wdata_q <= dataOut;
                        write_q <= 1'b1;
                        snoop_q <= 1'b0;
                        cnt_q   <= LAT_INIT;
                        busy_q  <= 1'b1;
                        state_q <= ACCESS;
                    end else if (readEnabled) begin
                        idx_q   <= address[IDX_W-1:0];
                        write_q <= 1'b0;
                        snoop_q <= 1'b0;
                        cnt_q   <= LAT_INIT;
                        busy_q  <= 1'b1;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!write_q && snoopHit && snoopFunctionComplete) begin
                        // Intervention preempts memory at any point.
                        snoop_data_q <= snoopDataIn;
                        snoop_q      <= 1'b1;
                        state_q      <= COMPLETE;
                    end else if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else if (write_q) begin
                        state_q <= COMPLETE;
                    end else if (!snoopHit) begin
                        data_in_q <= mem_q[idx_q];
                        state_q   <= COMPLETE;
                    end
                    // Otherwise an owner exists but has not supplied data:
                    // hold with the counter at zero.
                end
                COMPLETE: begin
                    if (!fc_q) begin
                        fc_q <= 1'b1;
                        if (snoop_q) begin
                            data_in_q <= snoop_data_q;
                        end
                    end else if (!readEnabled && !writeEnabled) begin
                        fc_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    fc_q    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_memory_controller.sv
module tb_bus_memory_controller;

    localparam int L       = 4;
    localparam int EXP_MEM = L + 1;

    logic        clock;
    logic        reset;
    logic [15:0] address;
    logic [15:0] dataOut;
    logic [15:0] dataIn;
    logic        readEnabled;
    logic        writeEnabled;
    logic        functionComplete;
    logic        snoopHit;
    logic        snoopFunctionComplete;
    logic [15:0] snoopDataIn;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] model [256];

    bus_memory_controller #(
        .ADDRESS_WIDTH(16),
        .DATA_WIDTH   (16),
        .SIZE_IN_WORDS(256),
        .LATENCY      (L)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .address              (address),
        .dataOut              (dataOut),
        .dataIn               (dataIn),
        .readEnabled          (readEnabled),
        .writeEnabled         (writeEnabled),
        .functionComplete     (functionComplete),
        .snoopHit             (snoopHit),
        .snoopFunctionComplete(snoopFunctionComplete),
        .snoopDataIn          (snoopDataIn),
        .busy                 (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drives one transaction and reports what was observed. lat counts edges
    // after the accepting edge until functionComplete is seen (-1 on timeout);
    // drop counts edges after the enables fall until it clears.
    task automatic txn(input logic wr, input logic rd, input logic [15:0] addr,
                       input logic [15:0] wd, input logic shit, input int sfc_edge,
                       input logic [15:0] sdata, output int lat,
                       output logic [15:0] rdata, output int drop,
                       output logic busy_acc, output logic busy_end);
        address               = addr;
        dataOut               = wd;
        writeEnabled          = wr;
        readEnabled           = rd;
        snoopHit              = shit;
        snoopFunctionComplete = 1'b0;
        snoopDataIn           = 16'($urandom);
        @(posedge clock); #1;
        busy_acc = busy;
        address  = 16'($urandom);
        dataOut  = 16'($urandom);
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            if (k == sfc_edge) begin
                snoopFunctionComplete = 1'b1;
                snoopDataIn           = sdata;
            end
            @(posedge clock); #1;
            if (k == sfc_edge) begin
                snoopFunctionComplete = 1'b0;
                snoopHit              = 1'b0;
                snoopDataIn           = 16'($urandom);
            end
            if (functionComplete) begin
                lat = k;
                break;
            end
        end
        rdata        = dataIn;
        writeEnabled = 1'b0;
        readEnabled  = 1'b0;
        snoopHit     = 1'b0;
        drop = -1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clock); #1;
            if (!functionComplete) begin
                drop = k;
                break;
            end
        end
        busy_end = busy;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (functionComplete !== 1'b0) begin
            errors++; $display("FAIL reset_fc got=%b want=0", functionComplete);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy got=%b want=0", busy);
        end
        checks++;
        if (dataIn !== 16'h0000) begin
            errors++; $display("FAIL reset_dataIn got=%h want=0000", dataIn);
        end
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_write_read;
        int lat, drop; logic [15:0] rd; logic ba, be;
        txn(1'b1, 1'b0, 16'h0012, 16'hBEEF, 1'b0, 0, 16'h0, lat, rd, drop, ba, be);
        model[8'h12] = 16'hBEEF;
        checks++;
        if (lat !== EXP_MEM) begin errors++; $display("FAIL wr_latency got=%0d want=%0d", lat, EXP_MEM); end
        checks++;
        if (drop !== 1) begin errors++; $display("FAIL wr_fc_drop got=%0d want=1", drop); end
        checks++;
        if (ba !== 1'b1 || be !== 1'b0) begin errors++; $display("FAIL wr_busy got=%b%b want=10", ba, be); end
        txn(1'b0, 1'b1, 16'h0012, 16'h0, 1'b0, 0, 16'h0, lat, rd, drop, ba, be);
        checks++;
        if (lat !== EXP_MEM) begin errors++; $display("FAIL rd_latency got=%0d want=%0d", lat, EXP_MEM); end
        checks++;
        if (rd !== 16'hBEEF) begin errors++; $display("FAIL rd_data got=%h want=BEEF", rd); end
    endtask

    task automatic test_random;
        int lat, drop; logic [15:0] rd; logic ba, be;
        logic [7:0] idxs [8];
        logic [7:0] ix;
        logic [15:0] wd;
        for (int i = 0; i < 8; i++) begin
            idxs[i] = 8'($urandom);
            wd = 16'($urandom);
            txn(1'b1, 1'b0, {8'($urandom), idxs[i]}, wd, 1'b0, 0, 16'h0, lat, rd, drop, ba, be);
            model[idxs[i]] = wd;
        end
        for (int i = 0; i < 24; i++) begin
            ix = idxs[$urandom_range(0, 7)];
            wd = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                txn(1'b1, 1'b0, {8'($urandom), ix}, wd, 1'b0, 0, 16'h0, lat, rd, drop, ba, be);
                model[ix] = wd;
            end else begin
                txn(1'b0, 1'b1, {8'($urandom), ix}, wd, 1'b0, 0, 16'h0, lat, rd, drop, ba, be);
                checks++;
                if (rd !== model[ix]) begin
                    errors++; $display("FAIL rand_rd_data idx=%h got=%h want=%h", ix, rd, model[ix]);
                end
            end
            checks++;
            if (lat !== EXP_MEM || drop !== 1) begin
                errors++; $display("FAIL rand_timing got=%0d/%0d want=%0d/1", lat, drop, EXP_MEM);
            end
        end
    endtask

    task automatic test_intervention;
        int lat, drop; logic [15:0] rd; logic ba, be;
        txn(1'b1, 1'b0, 16'h0020, 16'h1111, 1'b0, 0, 16'h0, lat, rd, drop, ba, be);
        txn(1'b0, 1'b1, 16'h0020, 16'h0, 1'b1, 2, 16'h2222, lat, rd, drop, ba, be);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL snoop_latency got=%0d want=3", lat); end
        checks++;
        if (rd !== 16'h2222) begin errors++; $display("FAIL snoop_data got=%h want=2222", rd); end
        txn(1'b0, 1'b1, 16'h0020, 16'h0, 1'b0, 0, 16'h0, lat, rd, drop, ba, be);
        checks++;
        if (rd !== 16'h2222) begin errors++; $display("FAIL snoop_flush got=%h want=2222", rd); end
        model[8'h20] = 16'h2222;
    endtask

    task automatic test_late_snoop;
        int lat, drop; logic [15:0] rd; logic ba, be;
        logic [15:0] sd;
        int se;
        txn(1'b1, 1'b0, 16'h0040, 16'h5555, 1'b0, 0, 16'h0, lat, rd, drop, ba, be);
        txn(1'b0, 1'b1, 16'h0040, 16'h0, 1'b1, 8, 16'h9999, lat, rd, drop, ba, be);
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL late_latency got=%0d want=9", lat); end
        checks++;
        if (rd !== 16'h9999) begin errors++; $display("FAIL late_data got=%h want=9999", rd); end
        model[8'h40] = 16'h9999;
        // Random owner response times, both before and after the memory latency.
        for (int i = 0; i < 8; i++) begin
            se = $urandom_range(1, 12);
            sd = 16'($urandom);
            txn(1'b0, 1'b1, 16'h0040, 16'h0, 1'b1, se, sd, lat, rd, drop, ba, be);
            model[8'h40] = sd;
            checks++;
            if (lat !== se + 1 || rd !== sd) begin
                errors++; $display("FAIL rand_snoop got=%0d/%h want=%0d/%h", lat, rd, se + 1, sd);
            end
        end
        txn(1'b0, 1'b1, 16'h0040, 16'h0, 1'b0, 0, 16'h0, lat, rd, drop, ba, be);
        checks++;
        if (rd !== model[8'h40]) begin errors++; $display("FAIL rand_snoop_flush got=%h want=%h", rd, model[8'h40]); end
    endtask

    task automatic test_both_enables;
        int lat, drop; logic [15:0] rd; logic ba, be;
        txn(1'b1, 1'b1, 16'h0005, 16'h00A5, 1'b0, 0, 16'h0, lat, rd, drop, ba, be);
        checks++;
        if (lat !== EXP_MEM) begin errors++; $display("FAIL both_latency got=%0d want=%0d", lat, EXP_MEM); end
        txn(1'b0, 1'b1, 16'h0005, 16'h0, 1'b0, 0, 16'h0, lat, rd, drop, ba, be);
        checks++;
        if (rd !== 16'h00A5) begin errors++; $display("FAIL both_readback got=%h want=00A5", rd); end
        model[8'h05] = 16'h00A5;
    endtask

    task automatic test_reset_midwrite;
        int lat, drop; logic [15:0] rd; logic ba, be;
        txn(1'b1, 1'b0, 16'h0030, 16'h0001, 1'b0, 0, 16'h0, lat, rd, drop, ba, be);
        txn(1'b0, 1'b1, 16'h0012, 16'h0, 1'b0, 0, 16'h0, lat, rd, drop, ba, be);
        address      = 16'h0030;
        dataOut      = 16'h7777;
        writeEnabled = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || functionComplete !== 1'b0) begin
            errors++; $display("FAIL midrst_ctrl got=%b%b want=00", busy, functionComplete);
        end
        checks++;
        if (dataIn !== 16'h0000) begin errors++; $display("FAIL midrst_dataIn got=%h want=0000", dataIn); end
        writeEnabled = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        txn(1'b0, 1'b1, 16'h0030, 16'h0, 1'b0, 0, 16'h0, lat, rd, drop, ba, be);
        checks++;
        if (rd !== 16'h0001) begin errors++; $display("FAIL midrst_mem got=%h want=0001", rd); end
    endtask

    task automatic test_wrap;
        int lat, drop; logic [15:0] rd; logic ba, be;
        txn(1'b1, 1'b0, 16'h0103, 16'h4242, 1'b0, 0, 16'h0, lat, rd, drop, ba, be);
        txn(1'b0, 1'b1, 16'h0003, 16'h0, 1'b0, 0, 16'h0, lat, rd, drop, ba, be);
        checks++;
        if (rd !== 16'h4242) begin errors++; $display("FAIL wrap_data got=%h want=4242", rd); end
    endtask

    task automatic test_enable_drop;
        int lat, drop; logic [15:0] rd; logic ba, be;
        int seen;
        address      = 16'h0077;
        dataOut      = 16'h3C3C;
        writeEnabled = 1'b1;
        @(posedge clock); #1;
        writeEnabled = 1'b0;
        seen = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clock); #1;
            if (functionComplete) begin seen = k; break; end
        end
        checks++;
        if (seen !== EXP_MEM) begin errors++; $display("FAIL drop_latency got=%0d want=%0d", seen, EXP_MEM); end
        @(posedge clock); #1;
        checks++;
        if (functionComplete !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL drop_pulse got=%b%b want=00", functionComplete, busy);
        end
        txn(1'b0, 1'b1, 16'h0077, 16'h0, 1'b0, 0, 16'h0, lat, rd, drop, ba, be);
        checks++;
        if (rd !== 16'h3C3C) begin errors++; $display("FAIL drop_mem got=%h want=3C3C", rd); end
    endtask

    initial begin
        address               = '0;
        dataOut               = '0;
        readEnabled           = 1'b0;
        writeEnabled          = 1'b0;
        snoopHit              = 1'b0;
        snoopFunctionComplete = 1'b0;
        snoopDataIn           = '0;
        test_reset();
        test_write_read();
        test_intervention();
        test_late_snoop();
        test_both_enables();
        test_reset_midwrite();
        test_wrap();
        test_enable_drop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
